// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. It owns the fetch PC, issues one
// imem request at a time, buffers returned words in a DEPTH-entry FIFO and
// presents {inst, inst_pc} to decode.
//
// Handshakes:
//   imem side   : imem_req/imem_addr are held until imem_ack. imem_ack is
//                 only sampled while imem_req=1.
//   decode side : the FIFO head is transferred on a cycle with
//                 inst_valid & inst_ready. A redirect_valid pulse flushes the
//                 FIFO on the same edge, and any pop in that cycle is ignored.
//
// Build option:
//   FETCH_BYPASS_EN - when the FIFO is empty, an accepted ack is presented on
//                     inst_* in the same cycle. If decode is ready, the word
//                     skips the FIFO. Without this macro, inst_* come only
//                     from registers.
module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_M = ~(ADDR_W'(3));

  // IDLE: no request outstanding. WAIT: request live. KILL: request live,
  // but its data is discarded because a redirect arrived.
  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
  logic [ADDR_W-1:0] req_pc, req_pc_next;
  logic [ADDR_W-1:0] redirect_aligned;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count, count_next;

  logic ack_taken, push, pop, fifo_valid;

  assign redirect_aligned = redirect_pc & ALIGN_M;
  assign ack_taken        = (state == WAIT) && imem_ack && !redirect_valid;
  assign fifo_valid       = (count != '0);
  assign pop              = fifo_valid && inst_ready && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = ack_taken && !fifo_valid;
  assign push       = ack_taken && !(bypass_hit && inst_ready);
  assign inst_valid = fifo_valid || bypass_hit;
  assign inst       = bypass_hit ? imem_rdata : inst_mem[rd_ptr];
  assign inst_pc    = bypass_hit ? req_pc     : pc_mem[rd_ptr];
`else
  assign push       = ack_taken;
  assign inst_valid = fifo_valid;
  assign inst       = inst_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
`endif

  assign count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign imem_req   = (state != IDLE);
  assign imem_addr  = req_pc;

  // Fetch FSM registers: state, next fetch address and in-flight address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
    end
  end

  // Next-state logic. A new request is issued only when the FIFO will have
  // room for its word, so the FIFO cannot overflow.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_pc_next   = req_pc;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_aligned;
        end else if (count_next < DEPTH_C) begin
          state_next  = WAIT;
          req_pc_next = fetch_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_aligned;
          state_next    = imem_ack ? IDLE : KILL;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc + PC_STEP;
          if (count_next < DEPTH_C) begin
            req_pc_next = req_pc + PC_STEP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      KILL: begin
        if (redirect_valid) fetch_pc_next = redirect_aligned;
        if (imem_ack)       state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prefetch FIFO. A redirect empties it on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. A combinational memory model returns word_of(addr).
// Directed cycle vectors are used for the main flow. Hand-written sequences
// cover asynchronous reset mid-fetch and the bypass build.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        ack;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = word_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add_vec(input logic ack, input logic ready, input logic redir,
                         input logic [31:0] rpc, input logic ereq,
                         input logic [31:0] eaddr, input logic evalid,
                         input logic [31:0] epc);
    vec_t v;
    v.ack = ack; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid; v.exp_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ack, input logic ready, input logic redir,
                       input logic [31:0] rpc);
    imem_ack       = ack;
    inst_ready     = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    check("rst_req",   {31'b0, imem_req},   32'h0);
    check("rst_addr",  imem_addr,           32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst",  inst,                32'h0);
    check("rst_pc",    inst_pc,             32'h0);

`ifndef FETCH_BYPASS_EN
    //       ack  rdy  rdr  rpc           req  addr          vld  pc
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'h4);
    add_vec(1'b1,1'b0,1'b0,32'h0,        1'b1,32'hC,        1'b1,32'h8);
    add_vec(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b1,32'h8);
    add_vec(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h14,       1'b1,32'h8);
    add_vec(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h14,       1'b1,32'h8);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h14,       1'b1,32'h8);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h18,       1'b1,32'hC);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h1C,       1'b1,32'h10);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h1C,       1'b1,32'h14);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h1C,       1'b1,32'h18);
    add_vec(1'b0,1'b1,1'b1,32'h100,      1'b1,32'h1C,       1'b0,32'h0);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h1C,       1'b0,32'h0);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h1C,       1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h1C,       1'b0,32'h0);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h1C,       1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h100,      1'b0,32'h0);
    add_vec(1'b1,1'b0,1'b1,32'h203,      1'b1,32'h104,      1'b1,32'h100);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h104,      1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h200,      1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b1,32'hFFFFFFFC, 1'b1,32'h204,      1'b1,32'h200);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h204,      1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'hFFFFFFFC, 1'b0,32'h0);
    add_vec(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'hFFFFFFFC);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0);
    add_vec(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b0,32'h0);

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("v%0d_req", i),   {31'b0, imem_req},   {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i),   inst_pc, vecs[i].exp_pc);
        check($sformatf("v%0d_inst", i), inst,    word_of(vecs[i].exp_pc));
      end
      drive(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
    end

    // Fill two FIFO entries, then assert reset while a request is in flight.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    check("pre_rst_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("mid_rst_req",   {31'b0, imem_req},   32'h0);
    check("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    check("mid_rst_addr",  imem_addr,           32'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    // Restart from RESET_PC with decode ready; check the in-order stream.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_BYPASS_EN
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(k * 4));
`else
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(k * 4));
`endif
    check("restart_req0", {31'b0, imem_req}, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_extra", inst_pc, 32'hDEADBEEF);
        end else begin
          check($sformatf("sb%0d_pc", c),   inst_pc, exp_q[0]);
          check($sformatf("sb%0d_inst", c), inst,    word_of(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
    check("sb_drained", exp_q.size(), 32'h0);

`ifdef FETCH_BYPASS_EN
    // Empty FIFO plus an accepted ack: the word is presented in the ack cycle.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check("byp_valid", {31'b0, inst_valid}, 32'h1);
    check("byp_pc",    inst_pc,             32'h0);
    check("byp_inst",  inst,                word_of(32'h0));
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    check("byp_not_buffered", {31'b0, inst_valid}, 32'h0);
    check("byp_next_addr",    imem_addr,           32'h4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
